// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence generator and its checker.
//   lfsr_state_t : checker FSM states (SEED, HUNT, LOCKED)
//   lfsr_fb      : feedback / prediction bit, XOR of the tapped register bits.
//                  Operands are zero-extended to LFSR_MAX_W, so LFSR widths up to 64 bits are supported.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_t;

  function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] seq,
                                   input logic [LFSR_MAX_W-1:0] poly);
    return ^(seq & poly);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Local LFSR of the checker; mirrors the generator register.
//   next      : clock
//   reset_n   : synchronous active-low reset (clears the register)
//   shift_en  : shift one step this cycle
//   use_pred  : load the predicted bit (free-run) instead of bit_in
//   bit_in    : received bit
//   char_poly : tap mask
//   pred_c    : combinational prediction of the next received bit
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         next,
  input  logic         reset_n,
  input  logic         shift_en,
  input  logic         use_pred,
  input  logic         bit_in,
  input  logic [N-1:0] char_poly,
  output logic         pred_c
);

  logic [N-1:0] seq;

  assign pred_c = lfsr_fb(LFSR_MAX_W'(seq), LFSR_MAX_W'(char_poly));

  // New bits enter at the MSB, matching the generator's LSB-first output.
  always_ff @(posedge next) begin
    if (!reset_n) begin
      seq <= '0;
    end else if (shift_en) begin
      seq <= {(use_pred ? pred_c : bit_in), seq[N-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// PRBS checker: seeds a local LFSR from the received stream, locks after
// LOCK_THRESH consecutive correct predictions, then free-runs and counts mismatches.
//   next       : clock
//   reset_n    : synchronous active-low reset
//   bit_valid  : qualifies bit_in; nothing changes when low
//   bit_in     : received bit
//   char_poly  : tap mask, static between resets
//   clr_cnt    : clears err_cnt (and bit_cnt); a same-cycle error still counts
//   locked     : high while in LOCKED
//   err_pulse  : one-cycle pulse per locked-state mismatch
//   err_cnt    : saturating count of locked-state mismatches
//   bit_cnt    : (LFSR_CHK_BITCNT_EN only) saturating count of bits compared while locked
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned LOCK_THRESH = 16,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             next,
  input  logic             reset_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [N-1:0]     char_poly,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
`ifdef LFSR_CHK_BITCNT_EN
  output logic [ERR_W+8-1:0] bit_cnt,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned SEED_W  = $clog2(N + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);

  lfsr_state_t        state, state_nxt;
  logic [SEED_W-1:0]  seed_cnt, seed_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [MISS_W-1:0]  miss_cnt, miss_nxt;
  logic [ERR_W-1:0]   err_base, err_nxt;
  logic               pred_c;
  logic               use_pred;
  logic               err_hit;

  lfsr_step #(.N(N)) u_step (
    .next      (next),
    .reset_n   (reset_n),
    .shift_en  (bit_valid),
    .use_pred  (use_pred),
    .bit_in    (bit_in),
    .char_poly (char_poly),
    .pred_c    (pred_c)
  );

  // Next-state and counter updates; only valid cycles advance.
  always_comb begin
    state_nxt = state;
    seed_nxt  = seed_cnt;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    use_pred  = 1'b0;
    err_hit   = 1'b0;
    if (bit_valid) begin
      case (state)
        SEED: begin
          if (seed_cnt == SEED_W'(N - 1)) begin
            state_nxt = HUNT;
            seed_nxt  = '0;
          end else begin
            seed_nxt = seed_cnt + 1'b1;
          end
        end
        HUNT: begin
          if (bit_in != pred_c) begin
            match_nxt = '0;
          end else if (match_cnt == MATCH_W'(LOCK_THRESH - 1)) begin
            state_nxt = LOCKED;
            match_nxt = '0;
            miss_nxt  = '0;
          end else begin
            match_nxt = match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a line error does not corrupt the register.
          use_pred = 1'b1;
          if (bit_in != pred_c) begin
            err_hit = 1'b1;
            if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
              match_nxt = '0;
            end else begin
              miss_nxt = miss_cnt + 1'b1;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = SEED;
      endcase
    end
  end

  // Clear first, then count, so clr_cnt with an error yields 1.
  always_comb begin
    err_base = clr_cnt ? '0 : err_cnt;
    err_nxt  = err_base;
    if (err_hit && (err_base != '1)) begin
      err_nxt = err_base + 1'b1;
    end
  end

  always_ff @(posedge next) begin
    if (!reset_n) begin
      state     <= SEED;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      seed_cnt  <= seed_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_hit;
      err_cnt   <= err_nxt;
    end
  end

`ifdef LFSR_CHK_BITCNT_EN
  localparam int unsigned BIT_W = ERR_W + 8;

  logic [BIT_W-1:0] bit_base, bit_nxt;

  // BER denominator: bits compared while locked.
  always_comb begin
    bit_base = clr_cnt ? '0 : bit_cnt;
    bit_nxt  = bit_base;
    if (bit_valid && (state == LOCKED) && (bit_base != '1)) begin
      bit_nxt = bit_base + 1'b1;
    end
  end

  always_ff @(posedge next) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: an 8-bit generator (INITIAL 8'h01, poly 8'h09)
// feeds two checkers, one with ERR_W=16 and one with ERR_W=4 for saturation.
// A queue-based behavioural model supplies the expected outputs every cycle.
module tb_lfsr_seq_checker;

  localparam int unsigned N     = 8;
  localparam int unsigned LOCKT = 16;
  localparam int unsigned LOSST = 4;
  localparam int unsigned ERR_W = 16;
  localparam int unsigned SAT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n, bit_valid, bit_in, clr_cnt;
  logic [N-1:0]     char_poly;
  logic             locked, err_pulse, s_locked, s_err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [SAT_W-1:0] s_err_cnt;
`ifdef LFSR_CHK_BITCNT_EN
  logic [ERR_W+7:0] bit_cnt;
  logic [SAT_W+7:0] s_bit_cnt;
`endif

  always #5 clk = ~clk;

  lfsr_seq_checker #(.N(N), .LOCK_THRESH(LOCKT), .LOSS_THRESH(LOSST), .ERR_W(ERR_W)) dut (
    .next(clk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .char_poly(char_poly), .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_cnt(bit_cnt),
`endif
    .err_cnt(err_cnt)
  );

  lfsr_seq_checker #(.N(N), .LOCK_THRESH(LOCKT), .LOSS_THRESH(LOSST), .ERR_W(SAT_W)) dut_sat (
    .next(clk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .char_poly(char_poly), .clr_cnt(clr_cnt), .locked(s_locked), .err_pulse(s_err_pulse),
`ifdef LFSR_CHK_BITCNT_EN
    .bit_cnt(s_bit_cnt),
`endif
    .err_cnt(s_err_cnt)
  );

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;

  // Behavioural model: last N effective bits, oldest first.
  bit     hist[$];
  int     m_seed, m_match, m_miss;
  bit     m_lock, m_pulse;
  longint m_err, m_serr, m_bits, m_sbits;
  logic [N-1:0] g_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit predict();
    bit p = 1'b0;
    for (int i = 0; i < int'(N); i++) if (char_poly[i]) p ^= hist[i];
    return p;
  endfunction

  function automatic longint sat_inc(input longint v, input int w);
    longint cap = (64'sd1 <<< w) - 1;
    return (v >= cap) ? cap : v + 1;
  endfunction

  task automatic push_bit(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  task automatic model_step(input bit rstn, input bit v, input bit b, input bit clr);
    bit p;
    m_pulse = 1'b0;
    if (!rstn) begin
      hist.delete();
      for (int i = 0; i < int'(N); i++) hist.push_back(1'b0);
      m_seed = 0; m_match = 0; m_miss = 0; m_lock = 1'b0;
      m_err = 0; m_serr = 0; m_bits = 0; m_sbits = 0;
      return;
    end
    if (clr) begin
      m_err = 0; m_serr = 0; m_bits = 0; m_sbits = 0;
    end
    if (!v) return;
    p = predict();
    if (m_seed < int'(N)) begin
      m_seed++;
      push_bit(b);
    end else if (!m_lock) begin
      if (b == p) begin
        m_match++;
        if (m_match == int'(LOCKT)) begin
          m_lock = 1'b1; m_match = 0; m_miss = 0;
        end
      end else begin
        m_match = 0;
      end
      push_bit(b);
    end else begin
      m_bits  = sat_inc(m_bits, ERR_W + 8);
      m_sbits = sat_inc(m_sbits, SAT_W + 8);
      if (b != p) begin
        m_pulse = 1'b1;
        m_err   = sat_inc(m_err, ERR_W);
        m_serr  = sat_inc(m_serr, SAT_W);
        m_miss++;
        if (m_miss == int'(LOSST)) begin
          m_lock = 1'b0; m_match = 0; m_miss = 0;
        end
      end else begin
        m_miss = 0;
      end
      push_bit(p);
    end
  endtask

  task automatic check_outputs();
    chk("locked", locked, m_lock);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_cnt", err_cnt, m_err);
    chk("sat_locked", s_locked, m_lock);
    chk("sat_err_cnt", s_err_cnt, m_serr);
`ifdef LFSR_CHK_BITCNT_EN
    chk("bit_cnt", bit_cnt, m_bits);
    chk("sat_bit_cnt", s_bit_cnt, m_sbits);
`endif
    if (err_pulse === 1'b1) n_pulse++;
  endtask

  task automatic cycle(input bit rstn, input bit v, input bit b, input bit clr);
    reset_n = rstn; bit_valid = v; bit_in = b; clr_cnt = clr;
    @(posedge clk);
    model_step(rstn, v, b, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic gen_bit(output bit b);
    bit fb;
    b = g_state[0];
    fb = ^(g_state & char_poly);
    g_state = {fb, g_state[N-1:1]};
  endtask

  // One cycle; the generator advances only on valid cycles, invalid cycles carry noise.
  task automatic send(input bit v, input bit flip, input bit clr);
    bit b;
    if (v) begin
      gen_bit(b);
      b ^= flip;
    end else begin
      b = 1'($urandom);
    end
    cycle(1'b1, v, b, clr);
  endtask

  // Returns the number of valid bits sent until locked is seen, or -1 on timeout.
  task automatic run_until_lock(input int maxv, input bit rand_valid, output int nvalid);
    int cyc = 0;
    bit v;
    nvalid = 0;
    while (locked !== 1'b1) begin
      if (nvalid >= maxv || cyc >= 8 * maxv) begin
        nvalid = -1;
        return;
      end
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      send(v, 1'b0, 1'b0);
      if (v) nvalid++;
      cyc++;
    end
  endtask

  initial begin
    int n;
    char_poly = 8'h09;
    g_state   = 8'h01;
    reset_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;

    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);

    // Clean stream: lock after N+LOCK_THRESH bits, no errors over 1000 bits.
    run_until_lock(100, 1'b0, n);
    chk("sc1_lock_point", n, 24);
    repeat (1000 - 24) send(1'b1, 1'b0, 1'b0);
    chk("sc1_err_cnt", err_cnt, 0);
    chk("sc1_locked", locked, 1'b1);

    // One inverted bit: exactly one pulse, no follow-on errors.
    n_pulse = 0;
    send(1'b1, 1'b1, 1'b0);
    repeat (50) send(1'b1, 1'b0, 1'b0);
    chk("sc2_pulses", n_pulse, 1);
    chk("sc2_err_cnt", err_cnt, 1);
    chk("sc2_locked", locked, 1'b1);

    // Four consecutive errors drop lock; clean resume relocks after LOCK_THRESH matches.
    send(1'b1, 1'b0, 1'b1);
    chk("sc3_cleared", err_cnt, 0);
    repeat (4) send(1'b1, 1'b1, 1'b0);
    chk("sc3_unlocked", locked, 1'b0);
    chk("sc3_err_cnt", err_cnt, 4);
    run_until_lock(100, 1'b0, n);
    chk("sc3_relock", n, 16);
    chk("sc3_err_kept", err_cnt, 4);

    // Reset while locked discards everything; relock from mid-stream.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sc6_locked", locked, 1'b0);
    chk("sc6_err_cnt", err_cnt, 0);
    run_until_lock(100, 1'b0, n);
    chk("sc6_relock", n, 24);

    // Saturation on the narrow counter, then clear coincident with an error.
    send(1'b1, 1'b0, 1'b1);
    repeat (6) begin
      repeat (3) send(1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b0, 1'b0);
    end
    chk("sc5_sat_cnt", s_err_cnt, 4'hF);
    chk("sc5_wide_cnt", err_cnt, 18);
    chk("sc5_locked", locked, 1'b1);
    send(1'b1, 1'b1, 1'b1);
    chk("sc5_clr_err", err_cnt, 1);
    chk("sc5_sat_clr_err", s_err_cnt, 1);

    // Random bit_valid: lock point in valid bits is unchanged.
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_until_lock(100, 1'b1, n);
    chk("sc4_lock_point", n, 24);
    repeat (1000) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("sc4_err_cnt", err_cnt, 0);
    chk("sc4_locked", locked, 1'b1);

    // Random valid, random line errors and clears, against the model.
    repeat (1500) send(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                       ($urandom_range(0, 63) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
